// File: rtl/calc_entry_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_entry_fsm: two-operand decimal keypad calculator entry controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
module calc_entry_fsm #(
  parameter int DIGITS = 3,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  output logic [W-1:0] operand_a,
  output logic [W-1:0] operand_b,
  output logic [W:0]   result,
  output logic         result_neg,
  output logic         result_valid,
  output logic         op_sub,
  output logic [2:0]   digit_count,
  output logic [W:0]   disp_value,
  output logic [1:0]   state_out
);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    RESULT  = 2'd2,
    UNUSED  = 2'd3
  } state_t;

  localparam logic [2:0] MAX_DIGITS = 3'(DIGITS);
  localparam logic [W:0] MAX_VALUE  = (W+1)'(10**DIGITS - 1);

  state_t       state_q, state_d;
  logic [W-1:0] operand_a_q, operand_a_d;
  logic [W-1:0] operand_b_q, operand_b_d;
  logic [W:0]   result_q, result_d;
  logic         result_neg_q, result_neg_d;
  logic         op_sub_q, op_sub_d;
  logic [2:0]   digit_count_q, digit_count_d;

  logic         is_digit, is_op, is_clear, is_back, is_equals;
  logic [W-1:0] active_op, op_push, op_pop;
  logic [W:0]   sum, diff;
  logic         a_ge_b;

  always_comb begin
    is_digit  = (key_code <= 4'h9);
    is_op     = (key_code == 4'hA) || (key_code == 4'hB);
    is_clear  = (key_code == 4'hC);
    is_back   = (key_code == 4'hE);
    is_equals = (key_code == 4'hF);

    active_op = (state_q == ENTER_B) ? operand_b_q : operand_a_q;
    // digit_count < DIGITS guarantees the shifted-in value fits in W bits
    op_push   = active_op * W'(10) + W'(key_code);
    op_pop    = active_op / W'(10);

    sum    = {1'b0, operand_a_q} + {1'b0, operand_b_q};
    a_ge_b = (operand_a_q >= operand_b_q);
    diff   = a_ge_b ? ({1'b0, operand_a_q} - {1'b0, operand_b_q})
                    : ({1'b0, operand_b_q} - {1'b0, operand_a_q});
  end

  always_comb begin
    state_d       = state_q;
    operand_a_d   = operand_a_q;
    operand_b_d   = operand_b_q;
    result_d      = result_q;
    result_neg_d  = result_neg_q;
    op_sub_d      = op_sub_q;
    digit_count_d = digit_count_q;

    if (key_valid && is_clear) begin
      state_d       = ENTER_A;
      operand_a_d   = '0;
      operand_b_d   = '0;
      result_d      = '0;
      result_neg_d  = 1'b0;
      op_sub_d      = 1'b0;
      digit_count_d = '0;
    end else begin
      case (state_q)
        ENTER_A, ENTER_B: begin
          if (key_valid) begin
            if (is_digit) begin
              if (digit_count_q < MAX_DIGITS) begin
                if (state_q == ENTER_B) operand_b_d = op_push;
                else                    operand_a_d = op_push;
                digit_count_d = digit_count_q + 3'd1;
              end
            end else if (is_back) begin
              if (digit_count_q != 3'd0) begin
                if (state_q == ENTER_B) operand_b_d = op_pop;
                else                    operand_a_d = op_pop;
                digit_count_d = digit_count_q - 3'd1;
              end
            end else if (is_op) begin
              op_sub_d = key_code[0];
              if (state_q == ENTER_A) begin
                operand_b_d   = '0;
                digit_count_d = '0;
                state_d       = ENTER_B;
              end
            end else if (is_equals && (state_q == ENTER_B)) begin
              if (op_sub_q) begin
                result_d     = diff;
                result_neg_d = ~a_ge_b;
              end else begin
                result_d     = sum;
                result_neg_d = 1'b0;
              end
              state_d = RESULT;
            end
          end
        end
        RESULT: begin
          if (key_valid) begin
            if (is_digit) begin
              operand_a_d   = W'(key_code);
              operand_b_d   = '0;
              digit_count_d = 3'd1;
              state_d       = ENTER_A;
            end else if (is_op && !result_neg_q && (result_q <= MAX_VALUE)) begin
              operand_a_d   = result_q[W-1:0];
              operand_b_d   = '0;
              digit_count_d = '0;
              op_sub_d      = key_code[0];
              state_d       = ENTER_B;
            end
          end
        end
        default: begin
          state_d       = ENTER_A;
          operand_a_d   = '0;
          operand_b_d   = '0;
          result_d      = '0;
          result_neg_d  = 1'b0;
          op_sub_d      = 1'b0;
          digit_count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ENTER_A;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      result_q      <= '0;
      result_neg_q  <= 1'b0;
      op_sub_q      <= 1'b0;
      digit_count_q <= '0;
    end else begin
      state_q       <= state_d;
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      result_q      <= result_d;
      result_neg_q  <= result_neg_d;
      op_sub_q      <= op_sub_d;
      digit_count_q <= digit_count_d;
    end
  end

  always_comb begin
    case (state_q)
      ENTER_A: disp_value = {1'b0, operand_a_q};
      ENTER_B: disp_value = {1'b0, operand_b_q};
      RESULT:  disp_value = result_q;
      default: disp_value = '0;
    endcase
  end

  assign operand_a    = operand_a_q;
  assign operand_b    = operand_b_q;
  assign result       = result_q;
  assign result_neg   = result_neg_q;
  assign result_valid = (state_q == RESULT);
  assign op_sub       = op_sub_q;
  assign digit_count  = digit_count_q;
  assign state_out    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_entry_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_calc_entry_fsm: table-driven directed bench for calc_entry_fsm.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_calc_entry_fsm;

  localparam int DIGITS = 3;
  localparam int W      = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         key_valid = 1'b0;
  logic [3:0]   key_code = 4'h0;
  logic [W-1:0] operand_a, operand_b;
  logic [W:0]   result, disp_value;
  logic         result_neg, result_valid, op_sub;
  logic [2:0]   digit_count;
  logic [1:0]   state_out;

  calc_entry_fsm #(.DIGITS(DIGITS), .W(W)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .operand_a(operand_a), .operand_b(operand_b), .result(result),
    .result_neg(result_neg), .result_valid(result_valid), .op_sub(op_sub),
    .digit_count(digit_count), .disp_value(disp_value), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       kv;
    logic       rst;
    logic [3:0] key;
    int st, a, b, res, neg, cnt, op;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic v(input logic kv, input logic rst, input logic [3:0] key,
                   input int st, input int a, input int b, input int res,
                   input int neg, input int cnt, input int op);
    vec_t e;
    e.kv = kv; e.rst = rst; e.key = key;
    e.st = st; e.a = a; e.b = b; e.res = res; e.neg = neg; e.cnt = cnt; e.op = op;
    vq.push_back(e);
  endtask

  task automatic k(input logic [3:0] key, input int st, input int a, input int b,
                   input int res, input int neg, input int cnt, input int op);
    v(1'b1, 1'b0, key, st, a, b, res, neg, cnt, op);
  endtask

  task automatic chk(input string tag, input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %0d expected %0d", tag, name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int a, input int b,
                           input int res, input int neg, input int cnt, input int op);
    int disp;
    disp = (st == 0) ? a : (st == 1) ? b : res;
    chk(tag, "state_out",    int'(state_out),    st);
    chk(tag, "operand_a",    int'(operand_a),    a);
    chk(tag, "operand_b",    int'(operand_b),    b);
    chk(tag, "result",       int'(result),       res);
    chk(tag, "result_neg",   int'(result_neg),   neg);
    chk(tag, "digit_count",  int'(digit_count),  cnt);
    chk(tag, "op_sub",       int'(op_sub),       op);
    chk(tag, "result_valid", int'(result_valid), (st == 2) ? 1 : 0);
    chk(tag, "disp_value",   int'(disp_value),   disp);
  endtask

  task automatic cycle(input logic rst, input logic kv, input logic [3:0] key);
    @(negedge clk);
    reset = rst; key_valid = kv; key_code = key;
    @(posedge clk);
    #1;
    key_valid = 1'b0; reset = 1'b0;
  endtask

  initial begin
    // reset
    v(1'b0, 1'b1, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    // 123 + 45
    k(4'h1, 0, 1, 0, 0, 0, 1, 0);
    k(4'h2, 0, 12, 0, 0, 0, 2, 0);
    k(4'h3, 0, 123, 0, 0, 0, 3, 0);
    k(4'hA, 1, 123, 0, 0, 0, 0, 0);
    k(4'h4, 1, 123, 4, 0, 0, 1, 0);
    k(4'h5, 1, 123, 45, 0, 0, 2, 0);
    k(4'hF, 2, 123, 45, 168, 0, 2, 0);
    k(4'hF, 2, 123, 45, 168, 0, 2, 0);
    k(4'hE, 2, 123, 45, 168, 0, 2, 0);
    k(4'hD, 2, 123, 45, 168, 0, 2, 0);
    k(4'hC, 0, 0, 0, 0, 0, 0, 0);
    // digit limit, 999 - 999
    k(4'h9, 0, 9, 0, 0, 0, 1, 0);
    k(4'h9, 0, 99, 0, 0, 0, 2, 0);
    k(4'h9, 0, 999, 0, 0, 0, 3, 0);
    k(4'h9, 0, 999, 0, 0, 0, 3, 0);
    k(4'hB, 1, 999, 0, 0, 0, 0, 1);
    k(4'h9, 1, 999, 9, 0, 0, 1, 1);
    k(4'h9, 1, 999, 99, 0, 0, 2, 1);
    k(4'h9, 1, 999, 999, 0, 0, 3, 1);
    k(4'h9, 1, 999, 999, 0, 0, 3, 1);
    k(4'h9, 1, 999, 999, 0, 0, 3, 1);
    k(4'hF, 2, 999, 999, 0, 0, 3, 1);
    k(4'hC, 0, 0, 0, 0, 0, 0, 0);
    // 12 - 50 negative, chaining refused
    k(4'h1, 0, 1, 0, 0, 0, 1, 0);
    k(4'h2, 0, 12, 0, 0, 0, 2, 0);
    k(4'hB, 1, 12, 0, 0, 0, 0, 1);
    k(4'h5, 1, 12, 5, 0, 0, 1, 1);
    k(4'h0, 1, 12, 50, 0, 0, 2, 1);
    k(4'hF, 2, 12, 50, 38, 1, 2, 1);
    k(4'hA, 2, 12, 50, 38, 1, 2, 1);
    // digit from RESULT, then empty operands
    k(4'h7, 0, 7, 0, 38, 1, 1, 1);
    k(4'hE, 0, 0, 0, 38, 1, 0, 1);
    k(4'hE, 0, 0, 0, 38, 1, 0, 1);
    k(4'hF, 0, 0, 0, 38, 1, 0, 1);
    k(4'hA, 1, 0, 0, 38, 1, 0, 0);
    k(4'hF, 2, 0, 0, 0, 0, 0, 0);
    k(4'hC, 0, 0, 0, 0, 0, 0, 0);
    // 500 + 500 = 1000, chaining refused
    k(4'h5, 0, 5, 0, 0, 0, 1, 0);
    k(4'h0, 0, 50, 0, 0, 0, 2, 0);
    k(4'h0, 0, 500, 0, 0, 0, 3, 0);
    k(4'hA, 1, 500, 0, 0, 0, 0, 0);
    k(4'h5, 1, 500, 5, 0, 0, 1, 0);
    k(4'h0, 1, 500, 50, 0, 0, 2, 0);
    k(4'h0, 1, 500, 500, 0, 0, 3, 0);
    k(4'hF, 2, 500, 500, 1000, 0, 3, 0);
    k(4'hB, 2, 500, 500, 1000, 0, 3, 0);
    k(4'h1, 0, 1, 0, 1000, 0, 1, 0);
    k(4'hF, 0, 1, 0, 1000, 0, 1, 0);
    k(4'hC, 0, 0, 0, 0, 0, 0, 0);
    // 999 + 0 = 999, chaining allowed at the limit
    k(4'h9, 0, 9, 0, 0, 0, 1, 0);
    k(4'h9, 0, 99, 0, 0, 0, 2, 0);
    k(4'h9, 0, 999, 0, 0, 0, 3, 0);
    k(4'hA, 1, 999, 0, 0, 0, 0, 0);
    k(4'h0, 1, 999, 0, 0, 0, 1, 0);
    k(4'hF, 2, 999, 0, 999, 0, 1, 0);
    k(4'hA, 1, 999, 0, 999, 0, 0, 0);
    k(4'h1, 1, 999, 1, 999, 0, 1, 0);
    k(4'hF, 2, 999, 1, 1000, 0, 1, 0);
    k(4'hC, 0, 0, 0, 0, 0, 0, 0);
    // backspace
    k(4'h7, 0, 7, 0, 0, 0, 1, 0);
    k(4'h8, 0, 78, 0, 0, 0, 2, 0);
    k(4'hE, 0, 7, 0, 0, 0, 1, 0);
    k(4'hE, 0, 0, 0, 0, 0, 0, 0);
    k(4'hE, 0, 0, 0, 0, 0, 0, 0);
    k(4'h6, 0, 6, 0, 0, 0, 1, 0);
    // operator overwrite in ENTER_B, then reset coincident with a key
    k(4'hC, 0, 0, 0, 0, 0, 0, 0);
    k(4'h4, 0, 4, 0, 0, 0, 1, 0);
    k(4'h2, 0, 42, 0, 0, 0, 2, 0);
    k(4'hA, 1, 42, 0, 0, 0, 0, 0);
    k(4'h3, 1, 42, 3, 0, 0, 1, 0);
    k(4'hB, 1, 42, 3, 0, 0, 1, 1);
    k(4'hE, 1, 42, 0, 0, 0, 0, 1);
    k(4'h3, 1, 42, 3, 0, 0, 1, 1);
    v(1'b1, 1'b1, 4'h5, 0, 0, 0, 0, 0, 0, 0);
    v(1'b0, 1'b0, 4'h5, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      cycle(vq[i].rst, vq[i].kv, vq[i].key);
      check_all($sformatf("vec%0d", i), vq[i].st, vq[i].a, vq[i].b,
                vq[i].res, vq[i].neg, vq[i].cnt, vq[i].op);
    end

    // reset held several cycles while keys keep strobing
    cycle(1'b0, 1'b1, 4'h8);
    check_all("pre_rst", 0, 8, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 4'(i + 1));
      check_all($sformatf("rst_hold%0d", i), 0, 0, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 4'h5);
      check_all($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0, 0);
    end
    cycle(1'b0, 1'b1, 4'h3);
    check_all("post_rst", 0, 3, 0, 0, 0, 1, 0);

    // result held across idle cycles; ignored key D in ENTER_B
    cycle(1'b0, 1'b1, 4'hC);
    cycle(1'b0, 1'b1, 4'h6);
    cycle(1'b0, 1'b1, 4'hA);
    cycle(1'b0, 1'b1, 4'hD);
    check_all("key_d", 1, 6, 0, 0, 0, 0, 0);
    cycle(1'b0, 1'b1, 4'h2);
    cycle(1'b0, 1'b1, 4'hF);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 4'hC);
      check_all($sformatf("hold%0d", i), 2, 6, 2, 8, 0, 1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
